divider_sd: RTL and testbench
=============================

# divider_sd

Parametrised sequential integer divider, successor to the fixed unsigned divider. It adds a per-operation signed/unsigned mode, a one-cycle `done` strobe, distinct divide-by-zero and signed-overflow flags, and a fast path for division by zero. It sits beside the existing arithmetic blocks as a multi-cycle datapath unit driven by a start/idle handshake.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥2). The iteration counter width is derived internally as `$clog2(WIDTH+1)`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `strt`  in  1  start request; sampled only while `idle`=1.
- `sgn`  in  1  1 = two's-complement signed operation, 0 = unsigned; sampled with `strt`.
- `dividend`  in  WIDTH  numerator; sampled with `strt`.
- `divisor`  in  WIDTH  denominator; sampled with `strt`.
- `quotient`  out  WIDTH  result quotient; registered; held until next completion.
- `remainder`  out  WIDTH  result remainder; registered; held until next completion.
- `not_valid`  out  1  divide-by-zero flag for the last completed operation.
- `ovf`  out  1  signed-overflow flag (MIN / −1) for the last completed operation.
- `done`  out  1  single-cycle pulse on the cycle the results become valid.
- `idle`  out  1  1 when able to accept `strt`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `strt`=1:
  - Latch `sgn`, the operand sign bits, and the operand magnitudes. In signed mode these are the absolute values; in unsigned mode the operands are taken as-is.
  - If `divisor`==0: go straight to FIX with the zero flag set.
  - Otherwise: clear the partial remainder, load counter = WIDTH, go to CALC.
- CALC, one restoring step per cycle:
  - Shift {partial remainder, magnitude dividend} left by 1.
  - If partial remainder ≥ magnitude divisor, subtract it and set the new quotient LSB to 1; otherwise the LSB is 0.
  - Decrement the counter. After WIDTH steps, go to FIX.
  - The partial remainder is WIDTH+1 bits internally, so no compare overflow when the divisor MSB is set.
- FIX, one cycle: write the outputs, pulse `done`, return to IDLE.
  - Divide by zero: `quotient` = all ones, `remainder` = the raw `dividend`, `not_valid`=1, `ovf`=0.
  - Signed mode: the quotient is negated when the operand signs differ, so it truncates toward zero. The remainder takes the sign of the dividend.
  - Signed, `dividend`=MIN and `divisor`=−1: `quotient`=MIN, `remainder`=0, `ovf`=1. This is also the natural result of the sign fix-up.
  - Otherwise both flags are 0.
- `strt` outside IDLE is ignored. No queueing.
- Operand inputs may change freely after the sampling edge.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `not_valid`=0, `ovf`=0, `done`=0, `idle`=1; state IDLE.
- Reset in CALC or FIX aborts the operation. No `done` is produced, and all outputs return to their reset values on that edge.
- Let edge E be the one that samples `strt`=1 in IDLE. `idle` falls after E.
- Normal operation: CALC spans edges E+1 … E+WIDTH, and FIX is entered after E+WIDTH. Results, flags, `done`=1 and `idle`=1 all appear together after edge E+WIDTH+1. Latency is WIDTH+1 cycles (33 at WIDTH=32).
- Divide by zero: results and `done` appear after edge E+1, a latency of 1 cycle.
- `done` is high for exactly one cycle.
- `strt` held high in the cycle `done` is high starts the next operation. Back-to-back throughput is WIDTH+2 cycles.
- Outputs change only on the FIX edge or on reset.

## Test plan
- Reset behaviour: after reset, all outputs are 0 and `idle`=1. Start 12339/9 unsigned → `done` 33 cycles after the start edge, q=1371, r=0, flags 0.
- Unsigned full range: 0xFFFFFFFF/0x0008A748 → q=7573, r=228119. Then 0xFFFFFFFF/0xFFFFFFFF with `sgn`=0 → q=1, r=0, and with `sgn`=1 (−1/−1) → q=1, r=0.
- Signed sign rules:
  - −7/2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1).
  - 7/−2 → q=−3, r=1.
  - −7/−2 → q=3, r=−1.
  - Then 0x80000000/0xFFFFFFFF with `sgn`=1 → q=0x80000000, r=0, `ovf`=1.
- Divide by zero: 0x0ABC6310/0 → `done` 1 cycle after the start edge, q=0xFFFFFFFF, r=0x0ABC6310, `not_valid`=1. The next valid divide clears `not_valid`.
- Handshake: pulse `strt` again 5 cycles into 0x0000ABCD/0x009837BC. The second pulse is ignored, and a single `done` reports q=0, r=0x0000ABCD. Holding `strt` through `done` launches the next operation immediately.
- Reset mid-operation: assert `rst` 10 cycles into a divide → no `done`, outputs 0, `idle`=1 next cycle. A following 165841528/20730191 → q=8, r=0.

Source files
------------

// File: rtl/divider_sd_if.sv
// rtl/divider_sd_if.sv - start/idle handshake and result bundle for divider_sd
interface divider_sd_if #(
    parameter int WIDTH = 32
);
    logic             strt;
    logic             sgn;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             not_valid;
    logic             ovf;
    logic             done;
    logic             idle;

    modport master (
        output strt, sgn, dividend, divisor,
        input  quotient, remainder, not_valid, ovf, done, idle
    );

    modport slave (
        input  strt, sgn, dividend, divisor,
        output quotient, remainder, not_valid, ovf, done, idle
    );
endinterface

// File: rtl/divider_sd.sv
// rtl/divider_sd.sv - sequential restoring signed/unsigned divider, one bit per cycle
module divider_sd #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    divider_sd_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             sgn_r;
    logic             dsign;
    logic             vsign;
    logic             zero_r;
    logic             ovf_r;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   prem;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   prem_step;
    logic             fits;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.strt) state_nxt = (bus.divisor == '0) ? FIX : CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // quo doubles as the shifting dividend; it ends up holding the quotient magnitude
    always_comb begin
        shifted   = {prem[WIDTH-1:0], quo[WIDTH-1]};
        fits      = shifted >= {1'b0, dsr};
        prem_step = fits ? (shifted - {1'b0, dsr}) : shifted;
        q_fix     = (sgn_r && (dsign ^ vsign)) ? -quo : quo;
        r_fix     = (sgn_r && dsign) ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            sgn_r         <= 1'b0;
            dsign         <= 1'b0;
            vsign         <= 1'b0;
            zero_r        <= 1'b0;
            ovf_r         <= 1'b0;
            quo           <= '0;
            dsr           <= '0;
            prem          <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.not_valid <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.strt) begin
                        sgn_r  <= bus.sgn;
                        dsign  <= bus.sgn & bus.dividend[WIDTH-1];
                        vsign  <= bus.sgn & bus.divisor[WIDTH-1];
                        zero_r <= (bus.divisor == '0);
                        ovf_r  <= bus.sgn && (bus.dividend == MIN) && (bus.divisor == '1);
                        prem   <= '0;
                        cnt    <= CW'(WIDTH);
                        dsr    <= (bus.sgn && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
                        // divide-by-zero keeps the raw dividend for the remainder output
                        if (bus.divisor == '0)
                            quo <= bus.dividend;
                        else
                            quo <= (bus.sgn && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                    end
                end
                CALC: begin
                    prem <= prem_step;
                    quo  <= {quo[WIDTH-2:0], fits};
                    cnt  <= cnt - CW'(1);
                end
                FIX: begin
                    bus.done <= 1'b1;
                    if (zero_r) begin
                        bus.quotient  <= '1;
                        bus.remainder <= quo;
                        bus.not_valid <= 1'b1;
                        bus.ovf       <= 1'b0;
                    end else begin
                        bus.quotient  <= q_fix;
                        bus.remainder <= r_fix;
                        bus.not_valid <= 1'b0;
                        bus.ovf       <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.idle = (state == IDLE);
endmodule

// File: tb/tb_divider_sd.sv
// tb/tb_divider_sd.sv - directed vector bench for divider_sd
module tb_divider_sd;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_sd_if #(.WIDTH(W)) bus ();
    divider_sd #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          sgn;
        logic [W-1:0]  dividend;
        logic [W-1:0]  divisor;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          nv;
        logic          ovf;
        int            lat;
    } vec_t;

    vec_t vecs [10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for done after the start edge; returns the cycle count or -1 on timeout.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.sgn      = s;
        bus.dividend = a;
        bus.divisor  = b;
        bus.strt     = 1'b1;
        @(posedge clk);
        #1;
        bus.strt     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
    endtask

    task automatic check_results(input string tag, input vec_t v);
        check({tag, "_q"},   bus.quotient,  v.q);
        check({tag, "_r"},   bus.remainder, v.r);
        check({tag, "_nv"},  bus.not_valid, v.nv);
        check({tag, "_ovf"}, bus.ovf,       v.ovf);
    endtask

    initial begin
        int   lat;
        int   n_done;
        int   first_done;
        vec_t v;

        vecs[0] = '{1'b0, 32'd12339,     32'd9,          32'd1371,     32'd0,        1'b0, 1'b0, 33};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,  32'h0008A748,   32'd7573,     32'd228119,   1'b0, 1'b0, 33};
        vecs[2] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,        32'd0,        1'b0, 1'b0, 33};
        vecs[3] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,        32'd0,        1'b0, 1'b0, 33};
        vecs[4] = '{1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
        vecs[5] = '{1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 33};
        vecs[6] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,        32'hFFFFFFFF, 1'b0, 1'b0, 33};
        vecs[7] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000, 32'd0,        1'b0, 1'b1, 33};
        vecs[8] = '{1'b0, 32'h0ABC6310,  32'd0,          32'hFFFFFFFF, 32'h0ABC6310, 1'b1, 1'b0, 1};
        vecs[9] = '{1'b0, 32'd100,       32'd7,          32'd14,       32'd2,        1'b0, 1'b0, 33};

        bus.strt = 1'b0; bus.sgn = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q",    bus.quotient,  '0);
        check("rst_r",    bus.remainder, '0);
        check("rst_nv",   bus.not_valid, 1'b0);
        check("rst_ovf",  bus.ovf,       1'b0);
        check("rst_done", bus.done,      1'b0);
        check("rst_idle", bus.idle,      1'b1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].sgn, vecs[i].dividend, vecs[i].divisor);
            check($sformatf("v%0d_busy", i), bus.idle, 1'b0);
            wait_done(lat);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_idle", i), bus.idle, 1'b1);
            check_results($sformatf("v%0d", i), vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse", i), bus.done, 1'b0);
        end

        // second strt mid-operation must be ignored
        start_op(1'b0, 32'h0000ABCD, 32'h009837BC);
        n_done = 0;
        first_done = -1;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) bus.strt = 1'b1;
            @(posedge clk);
            #1;
            bus.strt = 1'b0;
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
        check("hs_ndone", 64'(n_done), 64'd1);
        check("hs_lat", 64'(first_done), 64'd33);
        v = '{1'b0, 32'h0000ABCD, 32'h009837BC, 32'd0, 32'h0000ABCD, 1'b0, 1'b0, 33};
        check_results("hs", v);

        // strt held through done launches the next operation
        @(negedge clk);
        bus.sgn = 1'b0; bus.dividend = 32'd12339; bus.divisor = 32'd9; bus.strt = 1'b1;
        @(posedge clk);
        #1;
        bus.dividend = 32'd100; bus.divisor = 32'd7;
        wait_done(lat);
        check("b2b_lat_a", 64'(lat), 64'd33);
        check_results("b2b_a", vecs[0]);
        @(posedge clk);
        #1;
        bus.strt = 1'b0;
        check("b2b_busy", bus.idle, 1'b0);
        check("b2b_pulse", bus.done, 1'b0);
        wait_done(lat);
        check("b2b_lat_b", 64'(lat), 64'd33);
        check_results("b2b_b", vecs[9]);

        // reset in the middle of an operation
        start_op(1'b0, 32'd12339, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_q",    bus.quotient,  '0);
        check("mrst_r",    bus.remainder, '0);
        check("mrst_done", bus.done,      1'b0);
        check("mrst_idle", bus.idle,      1'b1);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("mrst_nodone", 64'(n_done), 64'd0);
        start_op(1'b0, 32'd165841528, 32'd20730191);
        wait_done(lat);
        check("mrst_lat", 64'(lat), 64'd33);
        v = '{1'b0, 32'd165841528, 32'd20730191, 32'd8, 32'd0, 1'b0, 1'b0, 33};
        check_results("mrst", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
